pe_array_feeder: RTL and testbench
==================================

# pe_array_feeder

Transmit-side feeder for the 8x8 PE array's vector input port. It accepts a 64-bit beat stream from on-chip memory and packs 16 beats into one 64-lane x 16-bit activation vector. Vectors are presented to the array with a pe_valid/pe_ready handshake through a ping-pong pair of vector buffers. It sequences a configured batch of vectors and signals completion; it sits between the activation buffer read path and the PE array.

## Interface
- LANES, 64, PE lanes per vector
- DATA_W, 16, bits per lane
- BEAT_LANES, 4, lanes carried per input beat (beat width = BEAT_LANES*DATA_W)
- CNT_W, 9, width of batch/vector counters (max batch 256)

- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a batch when idle
- cfg_num_vec  in  CNT_W  vectors in batch, sampled on accepted start; 0..256
- busy  out  1  high from accepted start until done cycle (inclusive)
- done  out  1  one-cycle pulse at batch completion
- vec_sent  out  CNT_W  vectors transferred to array in current/last batch
- s_data  in  BEAT_LANES*DATA_W  input beat; lane 4k+n at bits [16n+15:16n] of beat k
- s_valid  in  1  beat valid
- s_ready  out  1  beat accepted when s_valid && s_ready
- pe_input  out  LANES*DATA_W  flattened vector, lane i at [16i+15:16i]
- pe_valid  out  1  vector valid
- pe_ready  in  1  array ready; transfer when pe_valid && pe_ready

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: s_ready=0, pe_valid=0. start latches cfg_num_vec, clears vec_sent, vec_filled, and both buffers, then enters RUN. start outside IDLE is ignored.
- cfg_num_vec==0: IDLE->FINISH directly; done pulses the cycle after start with no transfers.
- RUN fill side: s_ready = fill buffer not full && vec_filled < num_vec. Beat counter 0..15 writes lanes 4k..4k+3. On the 16th beat the buffer is marked full, vec_filled increments, the fill pointer toggles, and the beat counter wraps to 0.
- RUN present side: pe_valid = present buffer full; pe_input = present buffer contents. On transfer the buffer is marked empty, the present pointer toggles, and vec_sent increments.
- When the last transfer makes vec_sent == num_vec: go to FINISH. FINISH drives done=1 and busy=1 for one cycle, then returns to IDLE.
- Both buffers full: s_ready=0 until a transfer frees one.
- Same-cycle fill-complete and transfer on different buffers: both take effect.
- Filling an empty buffer while the other is empty: the filled buffer becomes the present buffer (pointers stay consistent because they toggle in lockstep order).
- pe_input holds its last value when pe_valid=0; its contents are don't-care for verification.

## Timing
- Reset values: s_ready=0, pe_valid=0, pe_input=0, busy=0, done=0, vec_sent=0, state=IDLE, both buffers empty.
- start accepted at cycle t: busy=1 and s_ready=1 at t+1.
- Last (16th) beat accepted at t: pe_valid=1 at t+1 if that buffer is the present buffer. s_ready reflects the other buffer's status at t+1.
- pe_valid, once high, stays high with pe_input stable until the transfer. The feeder never retracts it.
- Steady state with continuous s_valid and pe_ready: one vector every 16 cycles; the stream is never stalled by the array.
- Final transfer at t: done=1 at t+1, busy=0 and state IDLE at t+2.
- rst asserted mid-batch: at the next edge all state returns to reset values and partial vectors are discarded. No done pulse.
- Counters never wrap: vec_filled and vec_sent are bounded by num_vec (max 256, fits CNT_W).

## Structure
- Shared definitions header gets LANES, DATA_W, BEAT_LANES, beats-per-vector (LANES/BEAT_LANES = 16) and the IDLE/RUN/FINISH state encoding. The PE array and its result drain use the same constants.
- One sub-module, pe_vec_buffer, is instantiated twice. It contains:
  - a 64x16 register file,
  - a beat-indexed 4-lane write port,
  - a full flag with set-on-last-beat and clear-on-transfer,
  - a flattened read port.
- pe_array_feeder holds the FSM, the pointers, the counters and the handshake logic.

## Test plan
- Single vector: cfg_num_vec=1, beats carry lane index as data (lane i = i), pe_ready=1 -> pe_valid rises 1 cycle after the 16th beat, pe_input lane 37 = 37, done 1 cycle after the transfer, vec_sent=1.
- Backpressure: cfg_num_vec=3, pe_ready=0 for 100 cycles -> s_ready drops after 32 beats, pe_input stays stable, no beat lost. After release, 3 transfers occur in order and vec_sent=3.
- Stream gaps: random s_valid with 50% duty, cfg_num_vec=256 -> exactly 256 transfers, data matches a scoreboard, done pulses once, and s_ready=0 after the 4096th beat.
- cfg_num_vec=0 -> done pulses at t+1 after start, pe_valid never asserted, busy high for exactly 1 cycle.
- Reset mid-batch: rst after 20 beats of a 4-vector batch -> all outputs at reset values next cycle. A new start with cfg_num_vec=1 then completes normally with fresh data only.
- start pulsed while busy -> ignored; num_vec and counters unchanged.

Source files
------------

// File: rtl/pe_array_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_feeder_pkg
// Description : Shared constants and state encoding for the PE array vector
//               path. These constants are shared by the PE array and its
//               result drain.
//               PE_LANES         lanes per activation vector
//               PE_DATA_W        bits per lane
//               PE_BEAT_LANES    lanes carried by one input beat
//               PE_BEATS_PER_VEC beats needed to fill one vector
//               PE_CNT_W         batch / vector counter width
// Revision    : 1.0 - initial release
// ============================================================================
package pe_array_feeder_pkg;

    localparam int PE_LANES         = 64;
    localparam int PE_DATA_W        = 16;
    localparam int PE_BEAT_LANES    = 4;
    localparam int PE_BEATS_PER_VEC = PE_LANES / PE_BEAT_LANES;
    localparam int PE_CNT_W         = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_array_feeder_vec_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pe_vec_buffer
// Description : One activation vector buffer of the feeder's ping-pong pair.
//               Lanes are written one beat (BEAT_LANES lanes) at a time at
//               the beat index; the buffer reports full after its last beat
//               and is emptied when the vector is handed to the array.
// Ports       : clk, rst       clock / synchronous active-high reset
//               i_clear        wipe contents and full flag (batch start)
//               i_wr_en        write one beat at i_wr_beat
//               i_wr_last      the written beat is the final one of a vector
//               i_wr_beat      beat index within the vector
//               i_wr_data      beat payload, lane n at [n*DATA_W +: DATA_W]
//               i_release      vector consumed by the array; clear full
//               o_full         buffer holds a complete vector
//               o_rd_data      flattened vector, lane i at [i*DATA_W +: DATA_W]
// Revision    : 1.0 - initial release
// ============================================================================
module pe_vec_buffer
    import pe_array_feeder_pkg::*;
#(
    parameter int LANES      = PE_LANES,
    parameter int DATA_W     = PE_DATA_W,
    parameter int BEAT_LANES = PE_BEAT_LANES,
    parameter int BEAT_IDX_W = $clog2(PE_LANES / PE_BEAT_LANES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_wr_en,
    input  logic                         i_wr_last,
    input  logic [BEAT_IDX_W-1:0]        i_wr_beat,
    input  logic [BEAT_LANES*DATA_W-1:0] i_wr_data,
    input  logic                         i_release,
    output logic                         o_full,
    output logic [LANES*DATA_W-1:0]      o_rd_data
);

    localparam int c_lane_aw = $clog2(LANES);

    logic [DATA_W-1:0] r_mem [LANES];
    logic              r_full;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < LANES; i++) begin
                r_mem[i] <= '0;
            end
            r_full <= 1'b0;
        end else begin
            if (i_wr_en) begin
                for (int n = 0; n < BEAT_LANES; n++) begin
                    r_mem[c_lane_aw'(int'(i_wr_beat) * BEAT_LANES + n)] <=
                        i_wr_data[n*DATA_W +: DATA_W];
                end
            end
            // Set and release never coincide: the feeder only writes a
            // buffer that is not full and only releases one that is.
            if (i_wr_en && i_wr_last) begin
                r_full <= 1'b1;
            end else if (i_release) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;

    for (genvar i = 0; i < LANES; i++) begin : g_rd
        assign o_rd_data[i*DATA_W +: DATA_W] = r_mem[i];
    end

endmodule
`default_nettype wire

// File: rtl/pe_array_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_feeder
// Description : Packs a 64-bit beat stream into 64-lane activation vectors
//               through a ping-pong buffer pair and presents them to the PE
//               array with a valid/ready handshake, sequencing a configured
//               batch and pulsing done at completion.
// Ports       : clk, rst            clock / synchronous active-high reset
//               start, cfg_num_vec  batch launch and batch length (0..256)
//               busy, done          batch in progress / completion pulse
//               vec_sent            vectors transferred in current/last batch
//               s_data/s_valid/s_ready   input beat stream
//               pe_input/pe_valid/pe_ready  vector output to the PE array
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array_feeder
    import pe_array_feeder_pkg::*;
#(
    parameter int LANES      = PE_LANES,
    parameter int DATA_W     = PE_DATA_W,
    parameter int BEAT_LANES = PE_BEAT_LANES,
    parameter int CNT_W      = PE_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             cfg_num_vec,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             vec_sent,
    input  logic [BEAT_LANES*DATA_W-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [LANES*DATA_W-1:0]      pe_input,
    output logic                         pe_valid,
    input  logic                         pe_ready
);

    localparam int c_beats      = LANES / BEAT_LANES;
    localparam int c_beat_idx_w = $clog2(c_beats);

    feeder_state_e           r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [CNT_W-1:0]        r_num_vec;
    logic [CNT_W-1:0]        r_vec_filled;
    logic [CNT_W-1:0]        r_vec_sent;
    logic [c_beat_idx_w-1:0] r_beat;
    // Fill and present pointers toggle in the same order, so the present
    // pointer always names the oldest complete vector.
    logic                    r_fill_ptr;
    logic                    r_pres_ptr;

    logic [1:0]                w_full;
    logic [LANES*DATA_W-1:0]   w_rd_data [2];
    logic                      w_clear;
    logic                      w_s_ready;
    logic                      w_beat_acc;
    logic                      w_last_beat;
    logic                      w_pe_valid;
    logic                      w_xfer;

    assign w_clear     = (r_state == ST_IDLE) && start;
    assign w_s_ready   = (r_state == ST_RUN) && !w_full[r_fill_ptr]
                         && (r_vec_filled < r_num_vec);
    assign w_beat_acc  = s_valid && w_s_ready;
    assign w_last_beat = (r_beat == c_beat_idx_w'(c_beats - 1));
    assign w_pe_valid  = (r_state == ST_RUN) && w_full[r_pres_ptr];
    assign w_xfer      = w_pe_valid && pe_ready;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        pe_vec_buffer #(
            .LANES      (LANES),
            .DATA_W     (DATA_W),
            .BEAT_LANES (BEAT_LANES),
            .BEAT_IDX_W (c_beat_idx_w)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .i_clear   (w_clear),
            .i_wr_en   (w_beat_acc && (r_fill_ptr == 1'(b))),
            .i_wr_last (w_last_beat),
            .i_wr_beat (r_beat),
            .i_wr_data (s_data),
            .i_release (w_xfer && (r_pres_ptr == 1'(b))),
            .o_full    (w_full[b]),
            .o_rd_data (w_rd_data[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_num_vec    <= '0;
            r_vec_filled <= '0;
            r_vec_sent   <= '0;
            r_beat       <= '0;
            r_fill_ptr   <= 1'b0;
            r_pres_ptr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_num_vec    <= cfg_num_vec;
                        r_vec_filled <= '0;
                        r_vec_sent   <= '0;
                        r_beat       <= '0;
                        r_fill_ptr   <= 1'b0;
                        r_pres_ptr   <= 1'b0;
                        r_busy       <= 1'b1;
                        if (cfg_num_vec == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_beat_acc) begin
                        if (w_last_beat) begin
                            r_beat       <= '0;
                            r_fill_ptr   <= ~r_fill_ptr;
                            r_vec_filled <= r_vec_filled + CNT_W'(1);
                        end else begin
                            r_beat <= r_beat + c_beat_idx_w'(1);
                        end
                    end
                    if (w_xfer) begin
                        r_pres_ptr <= ~r_pres_ptr;
                        r_vec_sent <= r_vec_sent + CNT_W'(1);
                        if (r_vec_sent + CNT_W'(1) == r_num_vec) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign vec_sent = r_vec_sent;
    assign s_ready  = w_s_ready;
    assign pe_valid = w_pe_valid;
    assign pe_input = w_rd_data[r_pres_ptr];

endmodule
`default_nettype wire

// File: tb/tb_pe_array_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_feeder
// Description : Self-checking bench for pe_array_feeder. Accepted beats are
//               packed into expected vectors and queued; a monitor pops and
//               compares at every vector transfer and tracks batch control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array_feeder;

    localparam int VEC_W = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [8:0]        cfg_num_vec;
    logic              busy;
    logic              done;
    logic [8:0]        vec_sent;
    logic [63:0]       s_data;
    logic              s_valid;
    logic              s_ready;
    logic [VEC_W-1:0]  pe_input;
    logic              pe_valid;
    logic              pe_ready;

    int total = 0;
    int bad   = 0;

    // driver controls
    bit drv_en   = 1'b0;
    bit idx_mode = 1'b0;
    int s_duty   = 100;
    int pr_duty  = 100;

    // shared model state (written with <= so same-edge readers see old value)
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_num  = 0;
    int m_sent = 0;
    int hs_count   = 0;
    int n_xfer     = 0;
    int n_done_dut = 0;

    logic [VEC_W-1:0] sb_q [$];

    pe_array_feeder u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_num_vec (cfg_num_vec),
        .busy        (busy),
        .done        (done),
        .vec_sent    (vec_sent),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .pe_input    (pe_input),
        .pe_valid    (pe_valid),
        .pe_ready    (pe_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Input side: pack accepted beats into expected vectors.
    initial begin : p_in
        logic [VEC_W-1:0] acc_vec;
        int acc_k;
        int b_batch;
        acc_vec = '0;
        acc_k   = 0;
        b_batch = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_k   = 0;
                acc_vec = '0;
                b_batch = 0;
                sb_q.delete();
            end else begin
                if (!m_busy && start) b_batch = 0;
                if (m_busy && b_batch == 16 * m_num)
                    chk("s_ready_after_last_beat", s_ready, 1'b0);
                if (s_valid && s_ready) begin
                    chk("beat_within_batch", b_batch < 16 * m_num, 1'b1);
                    hs_count <= hs_count + 1;
                    acc_vec[acc_k*64 +: 64] = s_data;
                    if (acc_k == 15) begin
                        sb_q.push_back(acc_vec);
                        acc_k = 0;
                    end else begin
                        acc_k++;
                    end
                    b_batch++;
                end
            end
        end
    end

    // Output side: vector scoreboard, handshake stability, batch control.
    initial begin : p_mon
        bit               pv_prev;
        logic [VEC_W-1:0] pin_prev;
        logic [VEC_W-1:0] exp_v;
        pv_prev  = 1'b0;
        pin_prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b0;
                m_sent  <= 0;
                m_num   <= 0;
                pv_prev = 1'b0;
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                chk("vec_sent", vec_sent, m_sent);
                if (!m_busy) begin
                    chk("idle_s_ready", s_ready, 1'b0);
                    chk("idle_pe_valid", pe_valid, 1'b0);
                end
                if (pv_prev) begin
                    chk("pe_valid_held", pe_valid, 1'b1);
                    total++;
                    if (pe_input !== pin_prev) begin
                        bad++;
                        $display("FAIL pe_input_stable: got %h, want %h", pe_input, pin_prev);
                    end
                end
                pv_prev  = pe_valid && !pe_ready;
                pin_prev = pe_input;
                if (done) n_done_dut <= n_done_dut + 1;
                if (pe_valid && pe_ready) begin
                    n_xfer <= n_xfer + 1;
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL vector_data: got transfer, want no vector pending");
                    end else begin
                        exp_v = sb_q.pop_front();
                        if (pe_input !== exp_v) begin
                            bad++;
                            $display("FAIL vector_data: got %h, want %h", pe_input, exp_v);
                        end
                    end
                    m_sent <= m_sent + 1;
                    if (m_sent + 1 == m_num) m_done <= 1'b1;
                end
                if (m_done) begin
                    m_done <= 1'b0;
                    m_busy <= 1'b0;
                end else if (!m_busy && start) begin
                    m_busy <= 1'b1;
                    m_num  <= int'(cfg_num_vec);
                    m_sent <= 0;
                    if (cfg_num_vec == 9'd0) m_done <= 1'b1;
                end
            end
        end
    end

    // Beat source and array ready driver.
    initial begin : p_drv
        bit         took;
        bit         rst_seen;
        logic [3:0] gen_k;
        s_valid  = 1'b0;
        s_data   = '0;
        pe_ready = 1'b0;
        gen_k    = '0;
        forever begin
            @(negedge clk);
            took     = s_valid && s_ready && !rst;
            rst_seen = rst;
            @(posedge clk);
            #1;
            if (rst_seen) gen_k = '0;
            else if (took) gen_k = gen_k + 4'd1;
            if (!drv_en) begin
                s_valid = 1'b0;
            end else if (!s_valid || took) begin
                s_valid = ($urandom_range(0, 99) < s_duty);
                if (idx_mode) begin
                    for (int n = 0; n < 4; n++)
                        s_data[16*n +: 16] = 16'(4 * int'(gen_k) + n);
                end else begin
                    s_data = {$urandom, $urandom};
                end
            end
            pe_ready = ($urandom_range(0, 99) < pr_duty);
        end
    end

    task automatic pulse_start(input logic [8:0] n);
        @(posedge clk); #1;
        start       = 1'b1;
        cfg_num_vec = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_within_bound", seen, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_beats(input int base, input int n, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (hs_count - base >= n) begin
                seen = 1'b1;
                break;
            end
        end
        chk("beats_within_bound", seen, 1'b1);
    endtask

    initial begin : p_watchdog
        #600000;
        $display("FAIL watchdog: got no finish, want finish within 60000 cycles");
        $fatal(1);
    end

    initial begin : p_stim
        int base;
        int x0;
        int d0;
        rst         = 1'b1;
        start       = 1'b0;
        cfg_num_vec = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_pe_valid", pe_valid, 1'b0);
        chk("rst_pe_input_zero", pe_input == '0, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_vec_sent", vec_sent, 9'd0);

        // single vector, lane index as data
        idx_mode = 1'b1; s_duty = 100; pr_duty = 100;
        base = hs_count;
        drv_en = 1'b1;
        pulse_start(9'd1);
        wait_beats(base, 16, 200);
        chk("single_pe_valid_after_16th", pe_valid, 1'b1);
        chk("single_lane37", pe_input[37*16 +: 16], 16'd37);
        wait_done(100);
        chk("single_vec_sent", vec_sent, 9'd1);
        @(posedge clk); #1 drv_en = 1'b0; idx_mode = 1'b0;

        // backpressure
        pr_duty = 0;
        repeat (3) @(negedge clk);
        base = hs_count;
        @(posedge clk); #1 drv_en = 1'b1;
        pulse_start(9'd3);
        repeat (100) @(negedge clk);
        chk("bp_beats_accepted", hs_count - base, 32);
        chk("bp_s_ready_low", s_ready, 1'b0);
        chk("bp_pe_valid_high", pe_valid, 1'b1);
        x0 = n_xfer;
        pr_duty = 100;
        wait_done(300);
        chk("bp_vec_sent", vec_sent, 9'd3);
        chk("bp_transfers", n_xfer - x0, 3);
        @(posedge clk); #1 drv_en = 1'b0;

        // zero-length batch
        repeat (2) @(negedge clk);
        x0 = n_xfer;
        pulse_start(9'd0);
        @(negedge clk);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b1);
        chk("zero_pe_valid", pe_valid, 1'b0);
        @(negedge clk);
        chk("zero_busy_drop", busy, 1'b0);
        chk("zero_no_transfer", n_xfer - x0, 0);

        // start while busy is ignored
        s_duty = 100; pr_duty = 100;
        @(posedge clk); #1 drv_en = 1'b1;
        pulse_start(9'd2);
        repeat (5) @(negedge clk);
        pulse_start(9'd5);
        wait_done(300);
        chk("busy_start_vec_sent", vec_sent, 9'd2);
        @(posedge clk); #1 drv_en = 1'b0;

        // reset mid-batch
        repeat (2) @(negedge clk);
        base = hs_count;
        @(posedge clk); #1 drv_en = 1'b1;
        pulse_start(9'd4);
        wait_beats(base, 20, 200);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_pe_valid", pe_valid, 1'b0);
        chk("midrst_pe_input_zero", pe_input == '0, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_vec_sent", vec_sent, 9'd0);
        x0 = n_xfer;
        pulse_start(9'd1);
        wait_done(200);
        chk("midrst_fresh_vec_sent", vec_sent, 9'd1);
        chk("midrst_fresh_transfers", n_xfer - x0, 1);
        @(posedge clk); #1 drv_en = 1'b0;

        // long batch with stream gaps
        repeat (2) @(negedge clk);
        s_duty = 50; pr_duty = 80;
        x0 = n_xfer;
        d0 = n_done_dut;
        base = hs_count;
        @(posedge clk); #1 drv_en = 1'b1;
        pulse_start(9'd256);
        wait_done(20000);
        repeat (3) @(negedge clk);
        chk("stream_transfers", n_xfer - x0, 256);
        chk("stream_done_pulses", n_done_dut - d0, 1);
        chk("stream_beats", hs_count - base, 4096);
        chk("stream_vec_sent", vec_sent, 9'd256);
        @(posedge clk); #1 drv_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
